// File: rtl/piecewise_inverse_fixed_if.sv
// Request/response bundle for piecewise_inverse_fixed: target y plus two
// segment coefficient pairs in, two candidate abscissae with flags out.
interface piecewise_inverse_fixed_if #(parameter int WID = 16);
    logic           in_valid;
    logic           in_ready;
    logic [WID-1:0] y, a0, a1, a2, a3;
    logic           out_valid;
    logic           out_ready;
    logic [WID-1:0] x0, x1;
    logic           dz0, dz1, ovf0, ovf1;

    modport master (
        output in_valid, y, a0, a1, a2, a3, out_ready,
        input  in_ready, out_valid, x0, x1, dz0, dz1, ovf0, ovf1
    );
    modport slave (
        input  in_valid, y, a0, a1, a2, a3, out_ready,
        output in_ready, out_valid, x0, x1, dz0, dz1, ovf0, ovf1
    );
endinterface

// File: rtl/piecewise_inverse_fixed.sv
// Inverse of the two-segment piecewise-linear map: x = (y - offset) / slope for
// both segments on one shared serial restoring divider. PIECEWISE_INV_SAT_EN
// selects saturating results on overflow / divide-by-zero (default: wrap / zero).
module piecewise_inverse_fixed #(
    parameter int WID   = 16,
    parameter int FBITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    piecewise_inverse_fixed_if.slave bus
);
    localparam int NB = WID + FBITS + 1;
    localparam int CW = $clog2(NB + 1);
    localparam logic [NB-1:0]  QMAXP = NB'(2 ** (WID - 1) - 1);
    localparam logic [NB-1:0]  QMAXN = NB'(2 ** (WID - 1));
    localparam logic [WID-1:0] XMAX  = {1'b0, {(WID-1){1'b1}}};
    localparam logic [WID-1:0] XMIN  = {1'b1, {(WID-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SETUP0, DIV0, FIN0, SETUP1, DIV1, FIN1, DONE} state_t;
    state_t state;

    logic signed [WID-1:0] yr, a0r, a1r, a2r, a3r;
    logic [NB-1:0]  nmag, quo;
    logic [WID-1:0] dmag, rem;
    logic [CW-1:0]  cnt;
    logic           qneg, dzero;

    // Setup: pick the segment, widen by one bit so y - offset cannot wrap.
    logic signed [WID-1:0] dsel, osel;
    logic signed [WID:0]   num;
    logic signed [NB-1:0]  numsh;
    logic [NB-1:0]         nmag_n;
    logic [WID-1:0]        dmag_n;
    assign dsel   = (state == SETUP1) ? a2r : a0r;
    assign osel   = (state == SETUP1) ? a3r : a1r;
    assign num    = {yr[WID-1], yr} - {osel[WID-1], osel};
    assign numsh  = {num, {FBITS{1'b0}}};
    assign nmag_n = numsh[NB-1] ? -numsh : numsh;
    assign dmag_n = dsel[WID-1] ? -dsel : dsel;

    // One restoring step: the partial remainder always stays below dmag.
    logic [WID:0]   rsh;
    logic [WID-1:0] rdiff;
    logic           ge;
    assign rsh   = {rem, nmag[NB-1]};
    assign ge    = rsh >= {1'b0, dmag};
    assign rdiff = rsh[WID-1:0] - dmag;

    // Finish: low bits of the signed quotient are the wrapped result.
    logic [WID-1:0] qs, x_n;
    logic           ovf_n;
    assign qs    = qneg ? -quo[WID-1:0] : quo[WID-1:0];
    assign ovf_n = !dzero && (qneg ? (quo > QMAXN) : (quo > QMAXP));

    always_comb begin
        x_n = qs;
`ifdef PIECEWISE_INV_SAT_EN
        // With a zero divisor qneg reduces to the sign of num.
        if (dzero || ovf_n) x_n = qneg ? XMIN : XMAX;
`else
        if (dzero) x_n = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.x0        <= '0;
            bus.x1        <= '0;
            bus.dz0       <= 1'b0;
            bus.dz1       <= 1'b0;
            bus.ovf0      <= 1'b0;
            bus.ovf1      <= 1'b0;
            yr <= '0; a0r <= '0; a1r <= '0; a2r <= '0; a3r <= '0;
            nmag <= '0; quo <= '0; dmag <= '0; rem <= '0; cnt <= '0;
            qneg <= 1'b0; dzero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    yr  <= bus.y;
                    a0r <= bus.a0;
                    a1r <= bus.a1;
                    a2r <= bus.a2;
                    a3r <= bus.a3;
                    bus.in_ready <= 1'b0;
                    state <= SETUP0;
                end
                SETUP0, SETUP1: begin
                    nmag  <= nmag_n;
                    dmag  <= dmag_n;
                    qneg  <= numsh[NB-1] ^ dsel[WID-1];
                    dzero <= (dsel == '0);
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= '0;
                    state <= (state == SETUP0) ? DIV0 : DIV1;
                end
                DIV0, DIV1: begin
                    rem  <= ge ? rdiff : rsh[WID-1:0];
                    quo  <= {quo[NB-2:0], ge};
                    nmag <= {nmag[NB-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(NB - 1)) state <= (state == DIV0) ? FIN0 : FIN1;
                end
                FIN0: begin
                    bus.x0   <= x_n;
                    bus.dz0  <= dzero;
                    bus.ovf0 <= ovf_n;
                    state    <= SETUP1;
                end
                FIN1: begin
                    bus.x1        <= x_n;
                    bus.dz1       <= dzero;
                    bus.ovf1      <= ovf_n;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piecewise_inverse_fixed.sv
// Scoreboard bench for piecewise_inverse_fixed: a plain-arithmetic model fills
// an expected-result queue; a negedge monitor pops it on each output handshake.
module tb_piecewise_inverse_fixed;
    localparam int WID   = 16;
    localparam int FBITS = 8;
    localparam int LAT   = 2 * (WID + FBITS + 3);

    typedef struct packed {
        logic [15:0] x0, x1;
        logic        dz0, dz1, ovf0, ovf1;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piecewise_inverse_fixed_if #(.WID(WID)) bus();
    piecewise_inverse_fixed #(.WID(WID), .FBITS(FBITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    res_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // x = (y - off) * 2^FBITS / d, truncated toward zero by integer division.
    function automatic void cand(input logic [15:0] y, input logic [15:0] d, input logic [15:0] off,
                                 output logic [15:0] x, output logic dz, output logic ovf);
        longint num, q;
        num = longint'($signed(y)) - longint'($signed(off));
        dz  = (d == 16'h0000);
        ovf = 1'b0;
        x   = 16'h0000;
        if (dz) begin
`ifdef PIECEWISE_INV_SAT_EN
            x = (num >= 0) ? 16'h7fff : 16'h8000;
`endif
        end else begin
            q   = (num * 256) / longint'($signed(d));
            ovf = (q > 32767) || (q < -32768);
            x   = q[15:0];
`ifdef PIECEWISE_INV_SAT_EN
            if (ovf) x = (q > 0) ? 16'h7fff : 16'h8000;
`endif
        end
    endfunction

    function automatic res_t model(input logic [15:0] y, a0, a1, a2, a3);
        res_t r;
        cand(y, a0, a1, r.x0, r.dz0, r.ovf0);
        cand(y, a2, a3, r.x1, r.dz1, r.ovf1);
        return r;
    endfunction

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        res_t got, e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            got = {bus.x0, bus.x1, bus.dz0, bus.dz1, bus.ovf0, bus.ovf1};
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                check("result", 64'(got), 64'(e));
            end
        end
    end

    // Latency: out_valid must rise exactly LAT cycles after the accept edge.
    always @(negedge clk) begin
        int a;
        if (rst) ov_prev = 1'b0;
        else begin
            if (bus.out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL latency: out_valid rose with no accepted request");
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 64'(cyc - a), 64'(LAT));
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(input logic [15:0] y, a0, a1, a2, a3);
        int n = 0;
        @(posedge clk); #1;
        bus.y = y; bus.a0 = a0; bus.a1 = a1; bus.a2 = a2; bus.a3 = a3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        acc_q.push_back(cyc);
        exp_q.push_back(model(y, a0, a1, a2, a3));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_x"},     64'({bus.x0, bus.x1}), 64'(0));
        check({tag, "_flags"}, 64'({bus.dz0, bus.dz1, bus.ovf0, bus.ovf1}), 64'(0));
    endtask

    initial begin
        logic [15:0] r [5];
        res_t snap;
        int   n;
        logic seen;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.y = '0; bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Directed: basic, truncation both signs, divide by zero, overflow.
        send(16'h0300, 16'h0200, 16'h0100, 16'hFF00, 16'h0000);
        send(16'h0100, 16'h0300, 16'h0000, 16'h0100, 16'h0000);
        send(16'hFF00, 16'h0300, 16'h0000, 16'h0100, 16'h0000);
        send(16'h0300, 16'h0000, 16'h0100, 16'h0200, 16'h0000);
        send(16'hFD00, 16'h0000, 16'h0100, 16'h0000, 16'hFF00);
        send(16'h7F00, 16'h0001, 16'h8000, 16'h0100, 16'h0000);
        send(16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000);
        drain();

        // Randomized requests with biased zero / tiny divisors.
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 5; k++) r[k] = 16'($urandom);
            case ($urandom_range(0, 5))
                0: r[1] = 16'h0000;
                1: r[3] = 16'h0000;
                2: r[1] = 16'($signed(4'($urandom)));
                3: r[3] = 16'($signed(6'($urandom)));
                default: ;
            endcase
            send(r[0], r[1], r[2], r[3], r[4]);
        end
        drain();

        // Backpressure: outputs hold, in_ready low, busy-time requests ignored.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(16'h0300, 16'h0200, 16'h0100, 16'hFF00, 16'h0000);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
        check("bp_out_valid", 64'(bus.out_valid), 64'(1));
        snap = {bus.x0, bus.x1, bus.dz0, bus.dz1, bus.ovf0, bus.ovf1};
        @(posedge clk); #1;
        bus.y = 16'h1234; bus.a0 = 16'h0001; bus.a1 = 16'h0000; bus.a2 = 16'h0000; bus.a3 = 16'h0000;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_hold", 64'({bus.out_valid, bus.x0, bus.x1, bus.dz0, bus.dz1, bus.ovf0, bus.ovf1}),
                  64'({1'b1, snap}));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hs_in_ready", 64'(bus.in_ready), 64'(1));
        check("hs_out_valid", 64'(bus.out_valid), 64'(0));
        check("hs_hold_x", 64'({bus.x0, bus.x1}), 64'({snap.x0, snap.x1}));
        send(16'h0100, 16'h0300, 16'h0000, 16'hFD00, 16'h0040);
        drain();

        // Reset mid-operation drops the request with no partial output.
        send(16'h0500, 16'h0300, 16'h0100, 16'h0200, 16'hFF00);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check_reset_values("midrst");
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_output", 64'(seen), 64'(0));
        send(16'h0300, 16'h0200, 16'h0100, 16'hFF00, 16'h0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
